// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encoding and a ceiling-log2 helper used to size the step counter.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/shift_add_step.sv
// One iteration of the right-shifting multiply: add the multiplicand into the
// upper half when the current multiplier bit is set, then shift right by one.
module shift_add_step #(
  parameter int unsigned NUM_BITS = 8
) (
  input  logic [2*NUM_BITS:0]  acc,
  input  logic [NUM_BITS-1:0]  mcand,
  input  logic                 mbit,
  output logic [2*NUM_BITS:0]  acc_next
);

  logic [NUM_BITS:0] hi_sum;

  // The upper half is one bit wider than the operand so the carry is kept.
  always_comb begin
    hi_sum   = acc[2*NUM_BITS:NUM_BITS] + (mbit ? {1'b0, mcand} : '0);
    acc_next = {hi_sum, acc[NUM_BITS-1:0]} >> 1;
  end

endmodule

// File: rtl/seq_mult_hs.sv
// Constant-time sequential signed/unsigned multiplier with a start/ready and
// done/ack handshake. Sign is handled as magnitude multiply plus final negate.
module seq_mult_hs
  import seq_mult_pkg::*;
#(
  parameter int unsigned NUM_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  in_ready,
  input  logic                  signed_mode,
  input  logic [NUM_BITS-1:0]   multiplier,
  input  logic [NUM_BITS-1:0]   multiplicand,
  output logic [2*NUM_BITS-1:0] product,
  output logic                  done,
  input  logic                  ack
);

  localparam int unsigned CW = clog2(NUM_BITS + 1);
  localparam int unsigned PW = 2 * NUM_BITS;

  state_t               state;
  logic [CW-1:0]        count;
  logic [2*NUM_BITS:0]  acc;
  logic [2*NUM_BITS:0]  acc_next;
  logic [NUM_BITS-1:0]  mcand;
  logic [NUM_BITS-1:0]  mplier;
  logic                 sign;

  function automatic logic [NUM_BITS-1:0] magnitude(input logic [NUM_BITS-1:0] value,
                                                    input logic              is_signed);
    return (is_signed && value[NUM_BITS-1]) ? -value : value;
  endfunction

  shift_add_step #(.NUM_BITS(NUM_BITS)) u_step (
    .acc      (acc),
    .mcand    (mcand),
    .mbit     (mplier[0]),
    .acc_next (acc_next)
  );

  // CALC runs NUM_BITS step cycles, then one closing cycle that applies the
  // sign and publishes the product, so done lands NUM_BITS+1 edges after accept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      count    <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      sign     <= 1'b0;
      product  <= '0;
      done     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mplier   <= magnitude(multiplier, signed_mode);
            mcand    <= magnitude(multiplicand, signed_mode);
            sign     <= signed_mode & (multiplier[NUM_BITS-1] ^ multiplicand[NUM_BITS-1]);
            count    <= '0;
            acc      <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          if (count == CW'(NUM_BITS)) begin
            product <= PW'(sign ? -acc : acc);
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            acc    <= acc_next;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
          end
        end
        DONE: begin
          if (ack) begin
            done     <= 1'b0;
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_hs.sv
// Directed self-checking bench for seq_mult_hs at NUM_BITS=7.
module tb_seq_mult_hs;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_ready;
  logic        signed_mode;
  logic [6:0]  multiplier;
  logic [6:0]  multiplicand;
  logic [13:0] product;
  logic        done;
  logic        ack;

  int checks = 0;
  int errors = 0;

  seq_mult_hs #(.NUM_BITS(7)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_ready     (in_ready),
    .signed_mode  (signed_mode),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .product      (product),
    .done         (done),
    .ack          (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_op(input logic [6:0] a, input logic [6:0] b, input logic s);
    multiplier   = a;
    multiplicand = b;
    signed_mode  = s;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (done !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic do_ack;
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++;
    if (product !== 14'd0) begin errors++; $display("FAIL reset_product: got %0d expected 0", product); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned_hold;
    int edges;
    start_op(7'd15, 7'd15, 1'b0);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL calc_in_ready: got %b expected 0", in_ready); end
    wait_done(edges);
    checks++;
    if (edges != 8) begin errors++; $display("FAIL latency_15x15: got %0d expected 8", edges); end
    checks++;
    if (product !== 14'd225) begin errors++; $display("FAIL product_15x15: got %0d expected 225", product); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b1 || product !== 14'd225 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: got done=%b product=%0d in_ready=%b expected 1 225 0", i, done, product, in_ready);
      end
    end
    do_ack();
    checks++;
    if (done !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL ack_release: got done=%b in_ready=%b expected 0 1", done, in_ready);
    end
    checks++;
    if (product !== 14'd225) begin errors++; $display("FAIL product_retained: got %0d expected 225", product); end
  endtask

  task automatic test_unsigned;
    int edges;
    start_op(7'd92, 7'd75, 1'b0);
    wait_done(edges);
    checks++;
    if (product !== 14'd6900) begin errors++; $display("FAIL product_92x75: got %0d expected 6900", product); end
    do_ack();
    start_op(7'd0, 7'd12, 1'b0);
    wait_done(edges);
    checks++;
    if (edges != 8) begin errors++; $display("FAIL latency_0x12: got %0d expected 8", edges); end
    checks++;
    if (product !== 14'd0) begin errors++; $display("FAIL product_0x12: got %0d expected 0", product); end
    do_ack();
  endtask

  task automatic test_signed;
    logic [6:0]  a_v [3];
    logic [6:0]  b_v [3];
    logic [13:0] p_v [3];
    int edges;
    a_v = '{7'h7D, 7'h40, 7'h40};
    b_v = '{7'd5,  7'h40, 7'd1};
    p_v = '{14'h3FF1, 14'd4096, 14'h3FC0};
    for (int i = 0; i < 3; i++) begin
      start_op(a_v[i], b_v[i], 1'b1);
      wait_done(edges);
      checks++;
      if (product !== p_v[i] || edges != 8) begin
        errors++;
        $display("FAIL signed_%0d: got product=%h edges=%0d expected %h 8", i, product, edges, p_v[i]);
      end
      do_ack();
    end
  endtask

  task automatic test_ignore;
    int edges;
    start_op(7'd42, 7'd78, 1'b0);
    @(posedge clk); #1;
    multiplier   = 7'd1;
    multiplicand = 7'd1;
    start        = 1'b1;
    ack          = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ack   = 1'b0;
    edges = 2;
    while (done !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    checks++;
    if (edges != 8) begin errors++; $display("FAIL latency_ignore: got %0d expected 8", edges); end
    checks++;
    if (product !== 14'd3276) begin errors++; $display("FAIL product_42x78: got %0d expected 3276", product); end
    do_ack();
  endtask

  task automatic test_reset_mid;
    int edges;
    int seen;
    start_op(7'd92, 7'd75, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    checks++;
    if (product !== 14'd0 || done !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got product=%0d done=%b in_ready=%b expected 0 0 1", product, done, in_ready);
    end
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL no_done_after_reset: got %0d done cycles expected 0", seen); end
    start_op(7'd1, 7'd2, 1'b0);
    wait_done(edges);
    checks++;
    if (product !== 14'd2) begin errors++; $display("FAIL product_1x2: got %0d expected 2", product); end
    do_ack();
  endtask

  task automatic test_back_to_back;
    int edges;
    start_op(7'd3, 7'd4, 1'b0);
    wait_done(edges);
    checks++;
    if (product !== 14'd12) begin errors++; $display("FAIL product_3x4: got %0d expected 12", product); end
    multiplier   = 7'd5;
    multiplicand = 7'd6;
    ack          = 1'b1;
    start        = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    checks++;
    if (done !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL ack_with_start: got done=%b in_ready=%b expected 0 1", done, in_ready);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL next_accept: got in_ready=%b expected 0", in_ready); end
    wait_done(edges);
    checks++;
    if (product !== 14'd30 || edges != 8) begin
      errors++; $display("FAIL product_5x6: got product=%0d edges=%0d expected 30 8", product, edges);
    end
    do_ack();
  endtask

  initial begin
    rst          = 1'b0;
    start        = 1'b0;
    ack          = 1'b0;
    signed_mode  = 1'b0;
    multiplier   = '0;
    multiplicand = '0;
    test_reset();
    test_unsigned_hold();
    test_unsigned();
    test_signed();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
